// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-fetch responder: FSM encoding,
// buffer entry layout and the default buffer depth.
package imem_pkg;

    localparam int IMEM_DEPTH_DEFAULT = 2;
    localparam int XLEN               = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        DRAIN    = 2'd2
    } imemState_e;

    // One buffered fetch result: fault flag, fetch address and instruction word.
    typedef struct packed {
        logic            err;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetchEntry_t;

    localparam int ENTRY_W = $bits(fetchEntry_t);

    function automatic fetchEntry_t makeEntry(input logic [XLEN-1:0] pc,
                                              input logic [XLEN-1:0] instr,
                                              input logic            err);
        fetchEntry_t e;
        e.err   = err;
        e.pc    = pc;
        e.instr = instr;
        return e;
    endfunction

    function automatic logic isAligned(input logic [XLEN-1:0] pc);
        return (pc[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/imem_fifo.sv
// Small synchronous FIFO holding completed fetches. Clear wins over any
// push or pop on the same edge; pointers wrap modulo DEPTH.
module imem_fifo
    import imem_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = IMEM_DEPTH_DEFAULT,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;
    logic             full;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign doPush  = push_i && !clear_i;
    assign doPop   = pop_i && !clear_i && (count_q != '0);
    assign data_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

    // Next pointer and occupancy values; clear returns everything to empty.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (clear_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) begin
                wrPtr_d = nextPtr(wrPtr_q);
            end
            if (doPop) begin
                rdPtr_d = nextPtr(rdPtr_q);
            end
            case ({doPush, doPop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer/count registers and entry storage, all cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            if (doPush) begin
                mem_q[wrPtr_q] <= data_i;
            end
        end
    end

    // The requester reserves space before issuing, so a push into a full buffer is a design bug.
    overflowCheck: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    !(push_i && !clear_i && full))
        else $error("imem_fifo: push while full");

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: accepts PCs from the IF stage, runs at most
// one bus read at a time, and queues results (or faults) for decode.
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] req_pc_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        flush_i,
    output logic [31:0] ibus_addr_o,
    output logic        ibus_cyc_o,
    input  logic [31:0] ibus_data_i,
    input  logic        ibus_ack_i,
    input  logic        ibus_err_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_err_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    imemState_e       state_q, state_d;
    logic [31:0]      busAddr_q, busAddr_d;
    logic             busCyc_q, busCyc_d;
    logic             accept;
    logic             busDone;
    logic             fifoPush;
    logic             fifoPop;
    fetchEntry_t      pushEntry;
    fetchEntry_t      headEntry;
    logic [CNT_W-1:0] count;

    assign req_ready_o = (state_q == IDLE) && (count < CNT_W'(DEPTH)) && !flush_i;
    assign accept      = req_valid_i && req_ready_o;
    assign busDone     = ibus_ack_i || ibus_err_i;

    assign ibus_addr_o   = busAddr_q;
    assign ibus_cyc_o    = busCyc_q;
    assign instr_valid_o = (count != '0);
    assign instr_o       = headEntry.instr;
    assign instr_pc_o    = headEntry.pc;
    assign instr_err_o   = headEntry.err;
    assign fifoPop       = instr_valid_o && instr_ready_i;

    // Next-state and bus/push control; a redirect during a read parks the FSM in DRAIN.
    always_comb begin
        state_d   = state_q;
        busAddr_d = busAddr_q;
        busCyc_d  = busCyc_q;
        fifoPush  = 1'b0;
        pushEntry = makeEntry(busAddr_q, ibus_data_i, ibus_err_i);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (isAligned(req_pc_i)) begin
                        busAddr_d = req_pc_i;
                        busCyc_d  = 1'b1;
                        state_d   = WAIT_ACK;
                    end else begin
                        fifoPush  = 1'b1;
                        pushEntry = makeEntry(req_pc_i, '0, 1'b1);
                    end
                end
            end
            WAIT_ACK: begin
                if (busDone) begin
                    busCyc_d = 1'b0;
                    state_d  = IDLE;
                    fifoPush = !flush_i;
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (busDone) begin
                    busCyc_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                busCyc_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // FSM state and registered bus outputs; reset drops any cycle in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            busAddr_q <= '0;
            busCyc_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            busAddr_q <= busAddr_d;
            busCyc_q  <= busCyc_d;
        end
    end

    imem_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifoPush),
        .pop_i   (fifoPop),
        .clear_i (flush_i),
        .data_i  (pushEntry),
        .data_o  (headEntry),
        .count_o (count)
    );

endmodule
